uart_tx_wb: RTL
===============

// Module: uart_tx_wb
// PURPOSE
//   Wishbone slave UART transmitter on one slave port of the 1-to-8 intercon_wb.
//   CPU writes bytes into a TX FIFO; an 8N1 serialiser drains them on tx_o.
//   Status and baud divider registers sit in the same 16-byte window.
//   Region decode (adr[22:20]) is upstream; this block decodes only adr[3:2].
// PARAMETERS
//   FIFO_DEPTH    16        TX FIFO entries, power of two, >= 2
//   BAUDDIV_RST   16'd433   BAUDDIV reset value; bit time = BAUDDIV+1 clk
// PORTS
//   clk        in   1   system clock
//   rst        in   1   reset, asynchronous, active-low
//   wb_dat_i   in   32  write data
//   wb_we_i    in   1   write enable
//   wb_sel_i   in   4   byte selects
//   wb_adr_i   in   32  byte address; only [3:2] used
//   wb_cyc_i   in   1   bus cycle
//   wb_stb_i   in   1   strobe
//   wb_dat_o   out  32  read data, valid while wb_ack_o=1
//   wb_ack_o   out  1   acknowledge
//   tx_o       out  1   serial output, idle high
// BEHAVIOUR
//   Reset (rst=0, async): wb_ack_o=0, wb_dat_o=0, tx_o=1, FIFO empty,
//     overflow=0, BAUDDIV=BAUDDIV_RST, FSM=IDLE, counters 0.
//   Handshake: request = cyc&stb&!wb_ack_o; wb_ack_o=1 exactly one cycle later,
//     then 0 for at least one cycle; every access acked, incl. unmapped ones.
//   Side effects (push, reg write) occur on the clock edge that raises ack.
//   Register map (adr[3:2]):
//     0 TXDATA  W: sel[0] pushes dat_i[7:0]; R: 0.
//     1 STATUS  R: [0]busy [1]full [2]empty [3]overflow [15:8]count, rest 0;
//               W: dat_i[3]=1 with sel[0] clears overflow.
//     2 BAUDDIV R/W [15:0]; sel[0]/sel[1] write bytes 0/1; [31:16] read 0.
//     3 unmapped: reads 0, writes ignored.
//   FIFO: count 0..FIFO_DEPTH; full/empty from count at start of cycle.
//     Push while full: byte dropped, overflow set (sticky), ack still given.
//     Push and pop same cycle with 0<count<DEPTH: count unchanged.
//     Pointers wrap modulo FIFO_DEPTH.
//   Serialiser FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//     IDLE: tx_o=1; if FIFO non-empty, pop head, load shifter, go START.
//     START tx_o=0, DATA tx_o=shifter bit, STOP tx_o=1; each BAUDDIV+1 clk.
//     Bit counter reloads from BAUDDIV at each bit start; a BAUDDIV write
//       mid-frame takes effect at the next bit boundary.
//     STOP end with FIFO non-empty: pop and go straight to START (no idle gap).
//     busy=1 whenever FSM != IDLE.
//   BAUDDIV=0: one clk per bit, a frame is 10 clk.
//   Reset mid-frame: tx_o returns to 1 immediately, queued data discarded.
// TESTING
//   Reset: rst=0 -> tx_o=1, wb_ack_o=0, STATUS read = 0x00000004, BAUDDIV = 433.
//   Ack timing: single read of STATUS with cyc=stb=1 held -> ack high 1 cycle
//     after request, low next cycle, pulses every 2nd cycle while held.
//   Frame: BAUDDIV=3, write 0xA5 to TXDATA -> tx_o = 0,1,0,1,0,0,1,0,1,1
//     each bit 4 clk, 40 clk total, then idle 1; busy=0 afterwards.
//   Back-to-back: BAUDDIV=0, write 0x00,0xFF -> 20 clk, no gap between frames;
//     STATUS count reads 1 after first pop.
//   Overflow: BAUDDIV=0xFFFF, write 18 bytes -> count=16, full=1, overflow=1;
//     write STATUS 0x8 -> overflow=0, full still 1.
//   Byte selects: write BAUDDIV 0x12345678 sel=4'b0001 -> reads 0x00000178;
//     TXDATA write with sel=4'b1110 -> no push, count unchanged.

Source files
------------

// File: rtl/uart_tx_wb.sv
// uart_tx_wb: Wishbone slave UART transmitter (8N1).
//   The CPU pushes bytes into a TX FIFO through the TXDATA register. A serialiser
//   drains the FIFO onto tx_o as 8N1 frames. Each bit lasts BAUDDIV+1 clocks.
//   Register window (decoded from adr[3:2] only):
//     0 TXDATA  W: sel[0] pushes dat[7:0]; reads 0
//     1 STATUS  R: [0]busy [1]full [2]empty [3]overflow [15:8]count
//               W: dat[3]=1 with sel[0] clears overflow
//     2 BAUDDIV R/W [15:0], written byte-wise by sel[1:0]
//     3 unmapped: reads 0, writes ignored
// Ports:
//   clk, rst (async, active-low)
//   wb_dat_i/wb_we_i/wb_sel_i/wb_adr_i/wb_cyc_i/wb_stb_i  Wishbone request
//   wb_dat_o/wb_ack_o                                     Wishbone response
//   tx_o                                                  serial line, idle high
module uart_tx_wb #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] BAUDDIV_RST = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [7:0]      shifter;
  logic [15:0]     baud_div;
  logic [15:0]     baud_cnt;
  logic [2:0]      bit_idx;
  logic            overflow;
  logic [31:0]     rdata;

  logic            req, full, empty, busy, push_req, push, pop, bit_end, load;
  logic [1:0]      reg_sel;
  logic            unused_ok;

  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  // A request is only taken while ack is low, which forces the idle cycle
  // between back-to-back accesses.
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign reg_sel  = wb_adr_i[3:2];
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != S_IDLE);
  assign push_req = req & wb_we_i & (reg_sel == 2'd0) & wb_sel_i[0];
  assign push     = push_req & ~full;
  assign bit_end  = (baud_cnt == 16'd0);

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      2'd1:    rdata = {16'd0, 8'(count), 4'd0, overflow, empty, full, busy};
      2'd2:    rdata = {16'd0, baud_div};
      default: rdata = 32'd0;
    endcase
  end

  // Bus response and register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      baud_div <= BAUDDIV_RST;
      overflow <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rdata : 32'd0;
      if (req & wb_we_i & (reg_sel == 2'd2)) begin
        if (wb_sel_i[0]) baud_div[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) baud_div[15:8] <= wb_dat_i[15:8];
      end
      if (push_req & full)
        overflow <= 1'b1;
      else if (req & wb_we_i & (reg_sel == 2'd1) & wb_sel_i[0] & wb_dat_i[3])
        overflow <= 1'b0;
    end
  end

  // FIFO control; pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_dat_i[7:0];
  end

  // Serialiser: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Serialiser: next state; a pop happens whenever a new frame is started
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:  if (!empty) begin
                 pop       = 1'b1;
                 state_nxt = S_START;
               end
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (bit_end) begin
                 if (!empty) begin
                   pop       = 1'b1;
                   state_nxt = S_START;
                 end else begin
                   state_nxt = S_IDLE;
                 end
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Serialiser: output
  always_comb begin
    tx_o = 1'b1;
    case (state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shifter[0];
      default: tx_o = 1'b1;
    endcase
  end

  // Bit timer reloads from the live divider at every bit start, so a divider
  // write mid-frame only changes the length of the following bits.
  assign load = (state_nxt != S_IDLE) && ((state == S_IDLE) || bit_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else begin
      if (load)
        baud_cnt <= baud_div;
      else if (busy)
        baud_cnt <= baud_cnt - 16'd1;
      if (state == S_START && bit_end)
        bit_idx <= 3'd0;
      else if (state == S_DATA && bit_end)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)
      shifter <= mem[rd_ptr];
    else if (state == S_DATA && bit_end)
      shifter <= {1'b0, shifter[7:1]};
  end

endmodule
